// File: rtl/flash_burst_reader_if.sv
// Wishbone read-master lines plus the valid/ready word stream of flash_burst_reader.
interface flash_burst_reader_if;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        i_wb_rty;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;

  modport master (
    output o_wb_adr, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
    input  i_wb_rdt, i_wb_ack, i_wb_rty,
    output o_data, o_valid,
    input  i_ready
  );

  modport slave (
    input  o_wb_adr, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
    output i_wb_rdt, i_wb_ack, i_wb_rty,
    input  o_data, o_valid,
    output i_ready
  );
endinterface

// File: rtl/flash_burst_reader.sv
// Turns one "read N words from A" command into single Wishbone reads, buffering
// the returned words in a first-word-fall-through FIFO with a running byte checksum.
module flash_burst_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RTY    = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic [31:0]                 i_base_adr,
  input  logic [15:0]                 i_count,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err,
  output logic [7:0]                  o_checksum,
  flash_burst_reader_if.master        bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RW = $clog2(MAX_RTY + 2);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_BUS, ST_DONE} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     adr_reg;
  logic [15:0]     remaining_reg;
  logic [RW-1:0]   rty_cnt_reg;
  logic [TW-1:0]   tmo_cnt_reg;
  logic            err_reg;
  logic [7:0]      checksum_reg;
  logic            wb_cyc_reg;
  logic [31:0]     wb_adr_reg;
  logic [3:0]      wb_sel_reg;

  logic [31:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     fifo_cnt_reg;
  logic            fifo_full, fifo_valid, push, pop;

  logic            start_take, ack_take, rty_take, abort_take, tmo_inc;
  logic [7:0]      byte_lane [4];
  logic [7:0]      byte_sum;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = bus.i_wb_rdt[8*gi +: 8];
    end
  endgenerate
  assign byte_sum = byte_lane[0] + byte_lane[1] + byte_lane[2] + byte_lane[3];

  assign fifo_full  = (fifo_cnt_reg == (AW+1)'(FIFO_DEPTH));
  assign fifo_valid = (fifo_cnt_reg != '0);
  // A request is only launched with a free slot, so an ack can always be pushed.
  assign push       = ack_take;
  assign pop        = fifo_valid && bus.i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start_take = 1'b0;
    ack_take   = 1'b0;
    rty_take   = 1'b0;
    abort_take = 1'b0;
    tmo_inc    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          start_take = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (remaining_reg == 16'd0) begin
          state_next = ST_DONE;
        end else if (!fifo_full) begin
          state_next = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus.i_wb_ack) begin
          ack_take   = 1'b1;
          state_next = ST_CHECK;
        end else if (bus.i_wb_rty) begin
          if (rty_cnt_reg < RW'(MAX_RTY)) begin
            rty_take   = 1'b1;
            state_next = ST_CHECK;
          end else begin
            abort_take = 1'b1;
            state_next = ST_DONE;
          end
        end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
          abort_take = 1'b1;
          state_next = ST_DONE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_reg       <= '0;
      remaining_reg <= '0;
      rty_cnt_reg   <= '0;
      tmo_cnt_reg   <= '0;
      err_reg       <= 1'b0;
      checksum_reg  <= '0;
    end else if (start_take) begin
      adr_reg       <= i_base_adr;
      remaining_reg <= i_count;
      rty_cnt_reg   <= '0;
      tmo_cnt_reg   <= '0;
      err_reg       <= 1'b0;
      checksum_reg  <= '0;
    end else if (ack_take) begin
      adr_reg      <= adr_reg + 32'd4;
      if (remaining_reg != 16'd0) begin
        remaining_reg <= remaining_reg - 16'd1;
      end
      rty_cnt_reg  <= '0;
      tmo_cnt_reg  <= '0;
      checksum_reg <= checksum_reg + byte_sum;
    end else if (rty_take) begin
      rty_cnt_reg <= rty_cnt_reg + RW'(1);
      tmo_cnt_reg <= '0;
    end else if (abort_take) begin
      err_reg     <= 1'b1;
      tmo_cnt_reg <= '0;
    end else if (tmo_inc) begin
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
    end
  end

  // Bus lines are registered from the next state so cyc/stb track BUS exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_cyc_reg <= 1'b0;
      wb_adr_reg <= '0;
      wb_sel_reg <= '0;
    end else begin
      wb_cyc_reg <= (state_next == ST_BUS);
      wb_sel_reg <= (state_next == ST_BUS) ? 4'hF : 4'h0;
      if (state_next == ST_BUS) begin
        wb_adr_reg <= adr_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bus.i_wb_rdt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + (AW+1)'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - (AW+1)'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  assign bus.o_wb_adr = wb_adr_reg;
  assign bus.o_wb_sel = wb_sel_reg;
  assign bus.o_wb_we  = 1'b0;
  assign bus.o_wb_cyc = wb_cyc_reg;
  assign bus.o_wb_stb = wb_cyc_reg;
  assign bus.o_data   = fifo_valid ? fifo_mem[rd_ptr_reg] : 32'd0;
  assign bus.o_valid  = fifo_valid;

  assign o_busy     = (state_reg != ST_IDLE);
  assign o_done     = (state_reg == ST_DONE);
  assign o_err      = err_reg;
  assign o_checksum = checksum_reg;
endmodule

// File: tb/tb_flash_burst_reader.sv
// Directed and randomized bursts against a behavioural Wishbone slave; results are
// compared with expectations computed from word counts, retry rules and byte sums.
module tb_flash_burst_reader;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_RTY    = 3;
  localparam int TIMEOUT    = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_base_adr = '0;
  logic [15:0] i_count = '0;
  logic        o_busy, o_done, o_err;
  logic [7:0]  o_checksum;

  flash_burst_reader_if bus ();

  flash_burst_reader #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_RTY    (MAX_RTY),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_base_adr (i_base_adr),
    .i_count    (i_count),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_checksum (o_checksum),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave configuration, owned by the main sequence.
  int          lat_cfg = 0;
  int          rty_cfg = 0;
  bit          silent_cfg = 1'b0;
  int          ready_mode = 0;
  logic [31:0] data_arr [64];

  // Slave-side observations, reset whenever a start is seen.
  logic [31:0] adr_q [$];
  logic [3:0]  sel_q [$];
  logic        we_q  [$];
  logic        gap_q [$];
  logic [31:0] got_q [$];
  int          stb_hi;
  int          cyc_stb_bad;

  initial begin
    int wait_cnt;
    int rty_left;
    int slv_idx;
    bus.i_wb_ack = 1'b0;
    bus.i_wb_rty = 1'b0;
    bus.i_wb_rdt = '0;
    wait_cnt = 0; rty_left = 0; slv_idx = 0; stb_hi = 0; cyc_stb_bad = 0;
    forever begin
      @(negedge clk);
      if (i_start) begin
        adr_q.delete(); sel_q.delete(); we_q.delete(); gap_q.delete();
        wait_cnt = 0; rty_left = rty_cfg; slv_idx = 0; stb_hi = 0; cyc_stb_bad = 0;
      end
      if (bus.o_wb_cyc !== bus.o_wb_stb) cyc_stb_bad++;
      if (bus.i_wb_ack || bus.i_wb_rty) begin
        gap_q.push_back(bus.o_wb_stb);
        bus.i_wb_ack = 1'b0;
        bus.i_wb_rty = 1'b0;
        wait_cnt = 0;
      end else if (bus.o_wb_stb) begin
        stb_hi++;
        if (!silent_cfg && wait_cnt >= lat_cfg) begin
          adr_q.push_back(bus.o_wb_adr);
          sel_q.push_back(bus.o_wb_sel);
          we_q.push_back(bus.o_wb_we);
          if (rty_left > 0) begin
            bus.i_wb_rty = 1'b1;
            rty_left--;
          end else begin
            bus.i_wb_ack = 1'b1;
            bus.i_wb_rdt = (slv_idx < 64) ? data_arr[slv_idx] : 32'hDEAD_BEEF;
            slv_idx++;
            rty_left = rty_cfg;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    bus.i_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.i_ready = 1'b1;
        2:       bus.i_ready = 1'($urandom_range(0, 1));
        default: bus.i_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (i_start) got_q.delete();
    if (bus.o_valid && bus.i_ready) got_q.push_back(bus.o_data);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_burst(input logic [31:0] base, input int cnt);
    i_base_adr = base;
    i_count    = 16'(cnt);
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
    chk("busy_after_start", 32'(o_busy), 1);
    chk("err_cleared", 32'(o_err), 0);
    chk("cks_cleared", 32'(o_checksum), 0);
    $display("start  base=%h count=%0d rty=%0d lat=%0d silent=%0d", base, cnt, rty_cfg, lat_cfg, silent_cfg);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!o_done && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("done_seen", 32'(o_done), 1);
    tick();
    chk("done_one_cycle", 32'(o_done), 0);
    chk("idle_after_done", 32'(o_busy), 0);
  endtask

  task automatic check_burst(input logic [31:0] base, input int cnt, input int rty, input bit silent);
    int          attempts, acked, exp_stb, k, n;
    logic        exp_err;
    logic [7:0]  cks;
    logic [31:0] w;
    if (cnt == 0) begin
      acked = 0; attempts = 0; exp_err = 1'b0;
    end else if (silent) begin
      acked = 0; attempts = 0; exp_err = 1'b1;
    end else if (rty > MAX_RTY) begin
      acked = 0; attempts = MAX_RTY + 1; exp_err = 1'b1;
    end else begin
      acked = cnt; attempts = cnt * (rty + 1); exp_err = 1'b0;
    end
    cks = 8'd0;
    for (int i = 0; i < acked; i++) begin
      w = data_arr[i];
      cks = cks + w[7:0] + w[15:8] + w[23:16] + w[31:24];
    end
    exp_stb = (silent && cnt > 0) ? TIMEOUT : attempts * (lat_cfg + 1);
    chk("err", 32'(o_err), 32'(exp_err));
    chk("checksum", 32'(o_checksum), 32'(cks));
    chk("n_requests", 32'(adr_q.size()), 32'(attempts));
    n = (adr_q.size() < attempts) ? adr_q.size() : attempts;
    for (int i = 0; i < n; i++) begin
      chk("req_adr", adr_q[i], base + 32'(4 * (i / (rty + 1))));
      chk("req_sel", 32'(sel_q[i]), 32'hF);
      chk("req_we", 32'(we_q[i]), 0);
    end
    for (int i = 0; i < gap_q.size(); i++) chk("stb_gap", 32'(gap_q[i]), 0);
    chk("stb_cycles", 32'(stb_hi), 32'(exp_stb));
    chk("cyc_eq_stb", 32'(cyc_stb_bad), 0);
    ready_mode = 1;
    k = 0;
    while ((got_q.size() < acked || bus.o_valid) && k < 200) begin
      tick();
      k++;
    end
    chk("fifo_drained", 32'(bus.o_valid), 0);
    chk("n_words", 32'(got_q.size()), 32'(acked));
    n = (got_q.size() < acked) ? got_q.size() : acked;
    for (int i = 0; i < n; i++) chk("word", got_q[i], data_arr[i]);
    $display("result base=%h count=%0d err=%0d cks=%h words=%0d reqs=%0d", base, cnt, o_err, o_checksum, got_q.size(), adr_q.size());
  endtask

  initial begin
    int          cyc;
    int          k;
    logic [31:0] base;
    int          cnt;

    // Reset state
    #2;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_cks", 32'(o_checksum), 0);
    chk("rst_cyc", 32'(bus.o_wb_cyc), 0);
    chk("rst_stb", 32'(bus.o_wb_stb), 0);
    chk("rst_sel", 32'(bus.o_wb_sel), 0);
    chk("rst_adr", bus.o_wb_adr, 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_data", bus.o_data, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single word, ack 2 cycles after stb
    data_arr[0] = 32'h0102_0304;
    lat_cfg = 2; rty_cfg = 0; silent_cfg = 1'b0; ready_mode = 0;
    start_burst(32'h0, 1);
    wait_done(200, cyc);
    chk("t1_valid", 32'(bus.o_valid), 1);
    chk("t1_data", bus.o_data, 32'h0102_0304);
    chk("t1_cks", 32'(o_checksum), 32'h0A);
    check_burst(32'h0, 1, 0, 1'b0);

    // Two words, checksum wraps
    data_arr[0] = 32'h0102_0304;
    data_arr[1] = 32'hFFFF_FFFF;
    lat_cfg = 0; ready_mode = 1;
    start_burst(32'h100, 2);
    wait_done(200, cyc);
    chk("t2_cks", 32'(o_checksum), 32'h06);
    check_burst(32'h100, 2, 0, 1'b0);

    // FIFO full stall with consumer blocked
    for (int i = 0; i < 6; i++) data_arr[i] = $urandom;
    lat_cfg = 1; ready_mode = 0;
    start_burst(32'h2000, 6);
    repeat (60) tick();
    chk("stall_reqs", 32'(adr_q.size()), 32'(FIFO_DEPTH));
    chk("stall_stb", 32'(bus.o_wb_stb), 0);
    chk("stall_busy", 32'(o_busy), 1);
    chk("stall_valid", 32'(bus.o_valid), 1);
    ready_mode = 1;
    wait_done(500, cyc);
    check_burst(32'h2000, 6, 0, 1'b0);

    // Three retries then ack succeeds
    data_arr[0] = 32'hCAFE_0001;
    lat_cfg = 0; rty_cfg = 3; ready_mode = 1;
    start_burst(32'h40, 1);
    wait_done(200, cyc);
    check_burst(32'h40, 1, 3, 1'b0);

    // Four retries abort the burst
    for (int i = 0; i < 3; i++) data_arr[i] = $urandom;
    rty_cfg = 4;
    start_burst(32'h80, 3);
    wait_done(200, cyc);
    check_burst(32'h80, 3, 4, 1'b0);

    // Silent slave times out
    rty_cfg = 0; silent_cfg = 1'b1;
    start_burst(32'h300, 2);
    wait_done(TIMEOUT + 50, cyc);
    check_burst(32'h300, 2, 0, 1'b1);

    // Zero count: err cleared by start, done two cycles after start
    silent_cfg = 1'b0;
    start_burst(32'h500, 0);
    wait_done(20, cyc);
    chk("zero_latency", 32'(cyc), 1);
    check_burst(32'h500, 0, 0, 1'b0);

    // Reset while a request is outstanding with data in the FIFO
    for (int i = 0; i < 3; i++) data_arr[i] = $urandom;
    lat_cfg = 4; ready_mode = 0;
    start_burst(32'h600, 3);
    k = 0;
    while (!(bus.o_wb_stb && adr_q.size() == 1) && k < 100) begin
      tick();
      k++;
    end
    chk("mid_stb", 32'(bus.o_wb_stb), 1);
    chk("mid_valid", 32'(bus.o_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(bus.o_wb_cyc), 0);
    chk("arst_stb", 32'(bus.o_wb_stb), 0);
    chk("arst_valid", 32'(bus.o_valid), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_done", 32'(o_done), 0);
    chk("arst_cks", 32'(o_checksum), 0);
    $display("reset  mid-burst cyc=%0d valid=%0d busy=%0d", bus.o_wb_cyc, bus.o_valid, o_busy);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", 32'(o_done), 0);

    // Randomized bursts
    for (int b = 0; b < 8; b++) begin
      base = $urandom & 32'hFFFF_FFFC;
      if (b == 2) base = 32'hFFFF_FFF8;
      cnt = int'($urandom_range(0, 9));
      rty_cfg = int'($urandom_range(0, 4));
      lat_cfg = int'($urandom_range(0, 3));
      ready_mode = int'($urandom_range(1, 2));
      silent_cfg = 1'b0;
      for (int i = 0; i < cnt; i++) data_arr[i] = $urandom;
      start_burst(base, cnt);
      wait_done(3000, cyc);
      check_burst(base, cnt, rty_cfg, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/flash_burst_reader.md
Name: flash_burst_reader

Overview:
Wishbone master that sits directly upstream of flash_controller. It turns one software/boot "read N words from address A" command into back-to-back single Wishbone read cycles. Returned words are buffered in a small first-word-fall-through FIFO with a valid/ready stream output. The block also keeps a running mod-256 byte checksum of the burst.

Parameters:
FIFO_DEPTH, 4, number of 32-bit entries in the output FIFO (power of two, >=2)
MAX_RTY, 3, retries allowed per word after o_wb_rty-style retry before abort
TIMEOUT, 1024, cycles in BUS state without ack/rty before abort

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
i_start  input  1  command strobe; sampled only in IDLE
i_base_adr  input  32  byte address of first word; latched on accepted i_start; must be 4-aligned
i_count  input  16  number of 32-bit words to read; latched on accepted i_start
o_busy  output  1  high from cycle after accepted i_start until DONE exits
o_done  output  1  one-cycle pulse at burst end (normal or abort)
o_err  output  1  sticky abort flag; cleared by next accepted i_start
o_checksum  output  8  mod-256 sum of all bytes of all words pushed this burst
o_wb_adr  output  32  Wishbone address
o_wb_sel  output  4  byte selects; 4'hF while o_wb_stb high, else 0
o_wb_we  output  1  constant 0, read-only master
o_wb_cyc  output  1  Wishbone cycle
o_wb_stb  output  1  Wishbone strobe
i_wb_rdt  input  32  read data from slave
i_wb_ack  input  1  slave acknowledge
i_wb_rty  input  1  slave retry request
o_data  output  32  FIFO head word
o_valid  output  1  FIFO non-empty
i_ready  input  1  consumer pop; pop when o_valid && i_ready

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; FIFO emptied; counters, address and checksum cleared. Reset mid-burst aborts with no o_done pulse.
- All Wishbone outputs are registered. o_wb_cyc equals o_wb_stb, and both are high only in BUS.
- States:
  - IDLE: on i_start, latch address and count, clear o_err, o_checksum and the retry count, go to CHECK. i_start outside IDLE is ignored.
  - CHECK: Wishbone lines low. If remaining==0, go to DONE. Else if FIFO not full, go to BUS. Else stay in CHECK.
  - BUS: cyc/stb/sel asserted and o_wb_adr=current address.
    - On i_wb_ack: push i_wb_rdt, add its 4 bytes to o_checksum (8-bit wrap), address+=4, remaining-=1, reset the retry count and timeout, go to CHECK.
    - Else on i_wb_rty: if the retry count < MAX_RTY, increment it and go to CHECK (same address is reissued). Otherwise set o_err and go to DONE.
    - Else increment the timeout counter. On reaching TIMEOUT, set o_err and go to DONE.
    - ack has priority over rty in the same cycle.
  - DONE: o_done=1 for one cycle, then IDLE.
- Bus is deasserted for at least one cycle between words. Minimum per-word cost is 2 cycles plus slave latency.
- Single outstanding request. A request is issued only when the FIFO is not full, so a push never overflows.
- The FIFO may pop during any state, including after DONE. A simultaneous push and pop keeps the occupancy unchanged.
- i_count==0: IDLE, CHECK, DONE with no bus cycle; o_done pulses 2 cycles after i_start and o_checksum=0.
- The address wraps modulo 2^32. The remaining count never underflows.
- o_busy=1 in CHECK, BUS and DONE.

Test Plan:
- Base 0x0, count 1; slave acks 2 cycles after stb with 0x01020304 -> one bus cycle at adr 0x0, sel=F, we=0; o_data=0x01020304 valid; o_checksum=0x0A; o_done pulse; o_err=0.
- Count 2, words 0x01020304 then 0xFFFFFFFF, base 0x100 -> addresses 0x100, 0x104; stb low ≥1 cycle between; o_checksum=0x06.
- Count 6, FIFO_DEPTH 4, i_ready=0 -> exactly 4 acks then CHECK stall, no stb. Raise i_ready -> remaining 2 read; all 6 words pop in order.
- Slave answers rty 3 times then ack -> 4 cycles at same address, success. rty 4 times -> o_err=1, o_done pulse, remaining words unread.
- Slave never answers -> stb held TIMEOUT cycles, then o_err=1 and o_done. A later i_start clears o_err.
- count=0 -> no cyc ever, o_done 2 cycles after start. rst_n low mid-BUS -> cyc/stb/o_valid drop immediately, state IDLE.
